// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART width and transmit-queue FSM encodings
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    s_IDLE      = 2'd0,
    s_LAUNCH    = 2'd1,
    s_WAIT_DONE = 2'd2
  } queueState_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock circular FIFO with registered read on pop
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_pushData,
  input  logic                  i_pop,
  output logic [WIDTH-1:0]      o_popData,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [ADDR_WIDTH:0]   o_count
);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [ADDR_WIDTH:0] wrPtr;
  logic [ADDR_WIDTH:0] rdPtr;
  logic                pushOk;
  logic                popOk;

  // Extra pointer MSB distinguishes a full ring from an empty one.
  assign o_empty = (wrPtr == rdPtr);
  assign o_full  = (wrPtr[ADDR_WIDTH] != rdPtr[ADDR_WIDTH]) &&
                   (wrPtr[ADDR_WIDTH-1:0] == rdPtr[ADDR_WIDTH-1:0]);
  assign o_count = wrPtr - rdPtr;

  assign popOk  = i_pop && !o_empty;
  assign pushOk = i_push && (!o_full || popOk);

  always_ff @(posedge i_clock) begin
    if (pushOk) begin
      mem[wrPtr[ADDR_WIDTH-1:0]] <= i_pushData;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      o_popData <= '0;
    end else begin
      if (pushOk) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (popOk) begin
        o_popData <= mem[rdPtr[ADDR_WIDTH-1:0]];
        rdPtr     <= rdPtr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - byte queue feeding uart_tx; UART_TX_QUEUE_OVERFLOW_EN enables sticky overflow
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_wrEn,
  input  logic [UART_DATA_WIDTH-1:0] i_wrData,
  input  logic                       i_clearOverflow,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [ADDR_WIDTH:0]        o_count,
  output logic                       o_overflow,
  output logic                       o_txBegin,
  output logic [UART_DATA_WIDTH-1:0] o_txData,
  input  logic                       i_txBusy,
  input  logic                       i_txDone
);

  queueState_t state;
  queueState_t nextState;
  logic        pop;
  logic        dropWrite;

  sync_fifo #(
    .WIDTH      (UART_DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) fifo (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_push     (i_wrEn),
    .i_pushData (i_wrData),
    .i_pop      (pop),
    .o_popData  (o_txData),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_count    (o_count)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= s_IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Launch waits on the registered empty flag, so a fresh byte is never popped in its write cycle.
  always_comb begin
    nextState = state;
    pop       = 1'b0;
    case (state)
      s_IDLE: begin
        if (!o_empty && !i_txBusy) begin
          pop       = 1'b1;
          nextState = s_LAUNCH;
        end
      end
      s_LAUNCH: begin
        nextState = s_WAIT_DONE;
      end
      s_WAIT_DONE: begin
        if (i_txDone) begin
          nextState = s_IDLE;
        end
      end
      default: begin
        nextState = s_IDLE;
      end
    endcase
  end

  assign o_txBegin = (state == s_LAUNCH);

  // A full queue still takes a write when the head leaves in the same cycle.
  assign dropWrite = i_wrEn && o_full && !pop;

`ifdef UART_TX_QUEUE_OVERFLOW_EN
  logic overflowReg;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      overflowReg <= 1'b0;
    end else if (dropWrite) begin
      overflowReg <= 1'b1;
    end else if (i_clearOverflow) begin
      overflowReg <= 1'b0;
    end
  end

  assign o_overflow = overflowReg;
`else
  logic unusedBits;

  assign unusedBits = i_clearOverflow ^ dropWrite;
  assign o_overflow = 1'b0;
`endif

endmodule
